// File: rtl/dds_mod_pkg.sv
// Shared types and constants for the DDS modulation phase generator.
// LFM support in the top level is enabled by defining DDS_MOD_LFM_EN.
package dds_mod_pkg;

    typedef enum logic [1:0] {
        MODE_CW   = 2'd0,
        MODE_BPSK = 2'd1,
        MODE_FSK  = 2'd2,
        MODE_LFM  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Half-turn phase offset for a phase word of the given width
    function automatic logic [31:0] pi_offset(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Enable-gated modulo-2^W phase accumulator with synchronous clear and a
// two-way increment select.
module dds_phase_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         sel,
    input  logic [W-1:0] inc0,
    input  logic [W-1:0] inc1,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + (sel ? inc1 : inc0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dds_mod_phase_gen.sv
// AXI-Stream phase-word generator for a DDS compiler: CW, BPSK, 2-FSK and,
// when DDS_MOD_LFM_EN is defined, linear-FM sweeps.
module dds_mod_phase_gen
    import dds_mod_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int MSG_W   = 13,
    parameter int CNT_W   = 16
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_dphase0,
    input  logic [PHASE_W-1:0] cfg_dphase1,
    input  logic [MSG_W-1:0]   cfg_msg,
    input  logic [CNT_W-1:0]   cfg_len,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [PHASE_W-1:0] m_axis_phase_tdata,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
    output logic               m_axis_phase_tlast,
    output logic               m_axis_phase_tuser
);

    localparam int BW = $clog2(MSG_W + 1);
    localparam logic [PHASE_W-1:0] PI_OFS = PHASE_W'(pi_offset(PHASE_W));

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [PHASE_W-1:0] dp0_q, dp0_d;
    logic [PHASE_W-1:0] dp1_q, dp1_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   samp_q, samp_d;
    logic [BW-1:0]      bits_q, bits_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               run;
    logic               hs;
    logic               bit_end;
    logic               last_beat;
    logic               cur_bit;
    logic               cfg_ok;
    logic               accept;
    logic               acc_sel;
    logic [PHASE_W-1:0] acc_inc0;
    logic [PHASE_W-1:0] acc;

`ifdef DDS_MOD_LFM_EN
    logic [PHASE_W-1:0] inc_q, inc_d;
    assign cfg_ok = (cfg_len != '0);
`else
    assign cfg_ok = (cfg_len != '0) && (cfg_mode != 2'd3);
`endif

    assign run       = (state_q == ST_RUN);
    assign hs        = run && m_axis_phase_tready;
    assign accept    = (state_q == ST_IDLE) && start && cfg_ok;
    assign bit_end   = (samp_q == len_q - CNT_W'(1));
    assign last_beat = bit_end && (bits_q == BW'(1));
    assign cur_bit   = ((mode_q == MODE_BPSK) || (mode_q == MODE_FSK)) && msg_q[0];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dp0_d   = dp0_q;
        dp1_d   = dp1_q;
        msg_d   = msg_q;
        len_d   = len_q;
        samp_d  = samp_q;
        bits_d  = bits_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !cfg_ok) begin
                    err_d = 1'b1;
                end else if (accept) begin
                    state_d = ST_RUN;
                    mode_d  = mode_e'(cfg_mode);
                    dp0_d   = cfg_dphase0;
                    dp1_d   = cfg_dphase1;
                    msg_d   = cfg_msg;
                    len_d   = cfg_len;
                    samp_d  = '0;
                    // CW and LFM run as a single "bit" of cfg_len samples
                    if ((cfg_mode == 2'd1) || (cfg_mode == 2'd2)) begin
                        bits_d = BW'(MSG_W);
                    end else begin
                        bits_d = BW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (bit_end) begin
                        samp_d = '0;
                        bits_d = bits_q - BW'(1);
                        msg_d  = msg_q >> 1;
                    end else begin
                        samp_d = samp_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CW;
            dp0_q   <= '0;
            dp1_q   <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            samp_q  <= '0;
            bits_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dp0_q   <= dp0_d;
            dp1_q   <= dp1_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            samp_q  <= samp_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef DDS_MOD_LFM_EN
    // Sweep rate register: starts at dphase0, grows by dphase1 per accepted beat
    always_comb begin
        inc_d = inc_q;
        if (accept) begin
            inc_d = cfg_dphase0;
        end else if (hs) begin
            inc_d = inc_q + dp1_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inc_q <= '0;
        end else begin
            inc_q <= inc_d;
        end
    end

    assign acc_inc0 = (mode_q == MODE_LFM) ? inc_q : dp0_q;
`else
    assign acc_inc0 = dp0_q;
`endif

    // FSK uses dphase1 for a 0 bit; every other mode steps by acc_inc0
    assign acc_sel = (mode_q == MODE_FSK) && !msg_q[0];

    dds_phase_acc #(
        .W (PHASE_W)
    ) u_acc (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (accept),
        .en    (hs),
        .sel   (acc_sel),
        .inc0  (acc_inc0),
        .inc1  (dp1_q),
        .acc   (acc)
    );

    assign m_axis_phase_tdata  = run ? (acc + (((mode_q == MODE_BPSK) && msg_q[0]) ? PI_OFS : '0)) : '0;
    assign m_axis_phase_tvalid = run;
    assign m_axis_phase_tlast  = run && last_beat;
    assign m_axis_phase_tuser  = run && cur_bit;
    assign busy                = run;
    assign done                = done_q;
    assign cfg_err             = err_q;

endmodule

// File: tb/tb_dds_mod_phase_gen.sv
// Directed self-checking bench for dds_mod_phase_gen (default 16/13/16 widths).
module tb_dds_mod_phase_gen;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_dphase0 = '0;
    logic [15:0] cfg_dphase1 = '0;
    logic [12:0] cfg_msg = '0;
    logic [15:0] cfg_len = '0;
    logic        busy, done, cfg_err;
    logic [15:0] tdata;
    logic        tvalid, tlast, tuser;
    logic        tready = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    dds_mod_phase_gen #(
        .PHASE_W (16),
        .MSG_W   (13),
        .CNT_W   (16)
    ) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .start               (start),
        .cfg_mode            (cfg_mode),
        .cfg_dphase0         (cfg_dphase0),
        .cfg_dphase1         (cfg_dphase1),
        .cfg_msg             (cfg_msg),
        .cfg_len             (cfg_len),
        .busy                (busy),
        .done                (done),
        .cfg_err             (cfg_err),
        .m_axis_phase_tdata  (tdata),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .m_axis_phase_tlast  (tlast),
        .m_axis_phase_tuser  (tuser)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] mode, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [12:0] msg, input logic [15:0] len);
        @(negedge aclk);
        cfg_mode    = mode;
        cfg_dphase0 = d0;
        cfg_dphase1 = d1;
        cfg_msg     = msg;
        cfg_len     = len;
        start       = 1'b1;
        @(posedge aclk);
        #1 start = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [15:0] data, input logic user, input logic last);
        @(negedge aclk);
        chk({tag, "_tvalid"}, 32'(tvalid), 32'd1);
        chk({tag, "_tdata"},  32'(tdata),  32'(data));
        chk({tag, "_tuser"},  32'(tuser),  32'(user));
        chk({tag, "_tlast"},  32'(tlast),  32'(last));
    endtask

    task automatic expect_done(input string tag);
        @(negedge aclk);
        chk({tag, "_done"},   32'(done),   32'd1);
        chk({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        @(negedge aclk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic expect_err(input string tag);
        @(negedge aclk);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd1);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_tvalid"},  32'(tvalid),  32'd0);
        @(negedge aclk);
        chk({tag, "_cfg_err_pulse"}, 32'(cfg_err), 32'd0);
        chk({tag, "_busy_idle"},     32'(busy),    32'd0);
    endtask

    // Walks a full PSK/FSK burst; the first four beats come from a hand table
    task automatic psk_fsk_burst(input string tag, input logic [1:0] mode, input logic [15:0] d0,
                                 input logic [15:0] d1, input logic [12:0] msg, input logic [15:0] len,
                                 input logic [15:0] h0, input logic [15:0] h1,
                                 input logic [15:0] h2, input logic [15:0] h3);
        logic [15:0] acc;
        logic [15:0] exp_d;
        logic [15:0] hand [4];
        logic        b;
        int          nbeats;
        hand[0] = h0; hand[1] = h1; hand[2] = h2; hand[3] = h3;
        nbeats = 13 * int'(len);
        acc = '0;
        do_start(mode, d0, d1, msg, len);
        for (int i = 0; i < nbeats; i++) begin
            b = msg[i / int'(len)];
            exp_d = (mode == 2'd1) ? acc + (b ? 16'h8000 : 16'h0000) : acc;
            if (i < 4) exp_d = hand[i];
            expect_beat($sformatf("%s_b%0d", tag, i), exp_d, b, i == nbeats - 1);
            if (mode == 2'd2) acc = acc + (b ? d0 : d1);
            else acc = acc + d0;
        end
        expect_done(tag);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_tdata",   32'(tdata),   32'd0);
        chk("rst_tvalid",  32'(tvalid),  32'd0);
        chk("rst_tlast",   32'(tlast),   32'd0);
        chk("rst_tuser",   32'(tuser),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // CW 2 MHz at 100 MHz
        do_start(2'd0, 16'd1310, 16'd0, 13'd0, 16'd4);
        expect_beat("cw_b0", 16'd0,    1'b0, 1'b0);
        expect_beat("cw_b1", 16'd1310, 1'b0, 1'b0);
        expect_beat("cw_b2", 16'd2620, 1'b0, 1'b0);
        expect_beat("cw_b3", 16'd3930, 1'b0, 1'b1);
        expect_done("cw");

        // BPSK: bit0=0, bit1=1, remaining bits 0
        psk_fsk_burst("bpsk", 2'd1, 16'd6553, 16'd0, 13'b0000000000010, 16'd2,
                      16'd0, 16'd6553, 16'd45874, 16'd52427);

        // FSK: bit0=0 steps by 6553, bit1=1 steps by 2621
        psk_fsk_burst("fsk", 2'd2, 16'd2621, 16'd6553, 13'b0000000000010, 16'd2,
                      16'd0, 16'd6553, 16'd13106, 16'd15727);

        // Backpressure: hold beat 1 for three stalled cycles
        do_start(2'd0, 16'd1310, 16'd0, 13'd0, 16'd4);
        expect_beat("bp_b0", 16'd0,    1'b0, 1'b0);
        expect_beat("bp_b1", 16'd1310, 1'b0, 1'b0);
        tready = 1'b0;
        expect_beat("bp_hold0", 16'd1310, 1'b0, 1'b0);
        chk("bp_hold0_busy", 32'(busy), 32'd1);
        expect_beat("bp_hold1", 16'd1310, 1'b0, 1'b0);
        expect_beat("bp_hold2", 16'd1310, 1'b0, 1'b0);
        tready = 1'b1;
        expect_beat("bp_b2", 16'd2620, 1'b0, 1'b0);
        expect_beat("bp_b3", 16'd3930, 1'b0, 1'b1);
        expect_done("bp");

        // LFM
        do_start(2'd3, 16'd3276, 16'd10, 13'd0, 16'd3);
`ifdef DDS_MOD_LFM_EN
        expect_beat("lfm_b0", 16'd0,    1'b0, 1'b0);
        expect_beat("lfm_b1", 16'd3276, 1'b0, 1'b0);
        expect_beat("lfm_b2", 16'd6562, 1'b0, 1'b1);
        expect_done("lfm");
`else
        expect_err("lfm_off");
`endif

        // Phase wrap
        do_start(2'd0, 16'h8000, 16'd0, 13'd0, 16'd3);
        expect_beat("wrap_b0", 16'h0000, 1'b0, 1'b0);
        expect_beat("wrap_b1", 16'h8000, 1'b0, 1'b0);
        expect_beat("wrap_b2", 16'h0000, 1'b0, 1'b1);
        expect_done("wrap");

        // Zero length rejected
        do_start(2'd0, 16'd100, 16'd0, 13'd0, 16'd0);
        expect_err("len0");

        // Reset mid-burst
        do_start(2'd0, 16'd1000, 16'd0, 13'd0, 16'd10);
        expect_beat("mid_b0", 16'd0,    1'b0, 1'b0);
        expect_beat("mid_b1", 16'd1000, 1'b0, 1'b0);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("mid_rst_tdata",  32'(tdata),  32'd0);
        chk("mid_rst_tvalid", 32'(tvalid), 32'd0);
        chk("mid_rst_tlast",  32'(tlast),  32'd0);
        chk("mid_rst_busy",   32'(busy),   32'd0);
        chk("mid_rst_done",   32'(done),   32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk($sformatf("mid_no_done%0d", i), 32'(done),   32'd0);
            chk($sformatf("mid_idle%0d", i),    32'(tvalid), 32'd0);
        end

        // Fresh burst after reset
        do_start(2'd0, 16'd7, 16'd0, 13'd0, 16'd2);
        expect_beat("post_b0", 16'd0, 1'b0, 1'b0);
        expect_beat("post_b1", 16'd7, 1'b0, 1'b1);
        expect_done("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_mod_phase_gen.md
# dds_mod_phase_gen

Synthesizable phase-word generator that drives the `s_axis_phase` port of a DDS compiler instance. Produces CW, BPSK, 2-FSK and, optionally, LFM phase sequences from a latched configuration, replacing hand-written stimulus tasks with hardware. AXI-Stream master with backpressure, parametrised in phase width, message length and symbol/sweep length.

## Interface
- `PHASE_W`, 16, phase word / accumulator width (DDS phase port width)
- `MSG_W`, 13, message bits per PSK/FSK burst
- `CNT_W`, 16, width of sample counter and `cfg_len`
- `aclk` in 1: single clock
- `aresetn` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse, latches all `cfg_*` and begins a burst
- `cfg_mode` in 2: 0 CW, 1 BPSK, 2 FSK, 3 LFM
- `cfg_dphase0` in PHASE_W: CW/BPSK increment; FSK increment for bit=1; LFM start increment
- `cfg_dphase1` in PHASE_W: FSK increment for bit=0; LFM per-sample increment step
- `cfg_msg` in MSG_W: message, sent LSB first
- `cfg_len` in CNT_W: samples per bit (BPSK/FSK) or total samples (CW/LFM)
- `busy` out 1: burst in progress
- `done` out 1: one-cycle pulse after last beat accepted
- `cfg_err` out 1: one-cycle pulse when `start` is rejected
- `m_axis_phase_tdata` out PHASE_W: phase word
- `m_axis_phase_tvalid` out 1
- `m_axis_phase_tready` in 1
- `m_axis_phase_tlast` out 1: final beat of burst
- `m_axis_phase_tuser` out 1: current message bit (0 in CW/LFM)

## Operation
- States: IDLE, RUN. IDLE→RUN on `start` with valid config; RUN→IDLE when final beat handshakes (`done` pulses the following cycle).
- Config latched on `start`; inputs ignored while `busy`. `start` during RUN: ignored, no `cfg_err`.
- Rejected start (`cfg_err`, stays IDLE): `cfg_len`==0, or mode 3 without LFM compiled in.
- Accumulator `acc` (PHASE_W, modulo 2^PHASE_W wrap) cleared to 0 on start; advances only on handshake.
- CW: tdata=acc; acc+=dphase0; cfg_len beats.
- BPSK: tdata=acc + (bit ? 2^(PHASE_W-1) : 0); acc+=dphase0; MSG_W*cfg_len beats.
- FSK: tdata=acc; acc+= bit ? dphase0 : dphase1; MSG_W*cfg_len beats.
- LFM: tdata=acc; acc+=inc; inc+=dphase1 (inc starts at dphase0, wraps); cfg_len beats.
- Bit index advances after cfg_len handshaken beats in the current bit; message shifted right.
- tlast on last beat only; tuser = current bit during BPSK/FSK.

## Timing
- Reset: tdata=0, tvalid=0, tlast=0, tuser=0, busy=0, done=0, cfg_err=0, acc=0, state IDLE.
- `start` at edge k → busy=1 and tvalid=1 with first sample from edge k+1 (1-cycle latency).
- Full throughput: one beat per cycle while tready=1.
- tvalid never drops and tdata/tlast/tuser stay stable while tvalid && !tready.
- Last handshake at edge m → tvalid=0, busy=0, done=1 at m+1; new `start` accepted at m+1.
- `aresetn` low mid-burst: immediate return to reset values, burst discarded, no `done`.

## Configuration
- `DDS_MOD_LFM_EN` defined: LFM mode, `inc` register and step adder present.
- Undefined: no `inc` logic; `start` with mode 3 → `cfg_err` pulse, stays IDLE.

## Structure
- Package `dds_mod_pkg`: mode enum (CW, BPSK, FSK, LFM), state enum, PI offset constant (1 << (PHASE_W-1)) as function of width.
- Sub-module `dds_phase_acc`: enable-gated PHASE_W accumulator with synchronous clear and selectable increment; instantiated once (LFM `inc` register lives in top).

## Test plan
- CW, dphase0=1310 (2 MHz @100 MHz), len=4, tready=1 → tdata 0,1310,2620,3930; tlast on 4th; done next cycle.
- BPSK, dphase0=6553, msg LSB bits 0,1, len=2 → 0,6553,45874,52427 (pi added on bit 1), tuser 0,0,1,1; 26 beats total, tlast on 26th.
- FSK, dphase0=2621, dphase1=6553, msg LSB=0, len=2 → 0,6553; bit 1 then steps by 2621.
- Backpressure: CW 1310, tready low 3 cycles after beat 2 → tdata held at 1310 throughout, then 2620, no sample lost or duplicated.
- LFM (macro on), dphase0=3276, dphase1=10, len=3 → 0,3276,6562; macro off → cfg_err pulse, busy stays 0.
- Wrap/reset/error: CW dphase0=0x8000, len=3 → 0,0x8000,0x0000; len=0 → cfg_err; aresetn low mid-burst → all outputs 0 next edge, no done.
